// File: rtl/vga_timing_gen.sv
// Purpose : two-axis VGA timing generator (SYNC -> BACK -> ACTIVE -> FRONT per axis) with
//           programmable lengths, sync polarity, data enable, coordinates and line/frame strobes.
// Latency : all outputs are registered and show the state entered on the most recent Pix_en tick.
// Backpr. : none; Pix_en=0 freezes state and outputs, and the strobes drop after one Clk.
//
// Ports
//   Clk, Rst_n            rising-edge clock, asynchronous active-low reset
//   Pix_en                pixel tick; state only advances on Clk edges with Pix_en=1
//   H_*_len / V_*_len     phase lengths (pixels / lines), sampled into a shadow copy at frame end
//   Hsync, Vsync          sync pulses, asserted level H_POL / V_POL while the axis is in SYNC
//   De, X, Y              data enable and active-area coordinates (0 outside the active area)
//   Line_start            one-Clk pulse on entering pixel 0 of a line
//   Frame_start           one-Clk pulse on entering pixel 0 of line 0
//   Cfg_err               sticky flag for a rejected zero-length reload
//
// Optional feature: define VGA_TIMING_CHECK_EN to reject reloads containing a zero length
// (previous shadow config kept, Cfg_err set). Without it Cfg_err is tied 0 and a zero
// length is loaded and behaves as a length of 1.

module vga_timing_gen #(
    parameter int                 REZ_MAX_WIDTH = 11,
    parameter bit                 H_POL         = 1'b0,
    parameter bit                 V_POL         = 1'b0,
    parameter logic [REZ_MAX_WIDTH-1:0] H_SYNC_DEF  = 96,
    parameter logic [REZ_MAX_WIDTH-1:0] H_BACK_DEF  = 48,
    parameter logic [REZ_MAX_WIDTH-1:0] H_ACT_DEF   = 640,
    parameter logic [REZ_MAX_WIDTH-1:0] H_FRONT_DEF = 16,
    parameter logic [REZ_MAX_WIDTH-1:0] V_SYNC_DEF  = 2,
    parameter logic [REZ_MAX_WIDTH-1:0] V_BACK_DEF  = 33,
    parameter logic [REZ_MAX_WIDTH-1:0] V_ACT_DEF   = 480,
    parameter logic [REZ_MAX_WIDTH-1:0] V_FRONT_DEF = 10
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Pix_en,
    input  logic [REZ_MAX_WIDTH-1:0] H_sync_len,
    input  logic [REZ_MAX_WIDTH-1:0] H_back_len,
    input  logic [REZ_MAX_WIDTH-1:0] H_act_len,
    input  logic [REZ_MAX_WIDTH-1:0] H_front_len,
    input  logic [REZ_MAX_WIDTH-1:0] V_sync_len,
    input  logic [REZ_MAX_WIDTH-1:0] V_back_len,
    input  logic [REZ_MAX_WIDTH-1:0] V_act_len,
    input  logic [REZ_MAX_WIDTH-1:0] V_front_len,
    output logic                     Hsync,
    output logic                     Vsync,
    output logic                     De,
    output logic [REZ_MAX_WIDTH-1:0] X,
    output logic [REZ_MAX_WIDTH-1:0] Y,
    output logic                     Line_start,
    output logic                     Frame_start,
    output logic                     Cfg_err
);

    localparam int W = REZ_MAX_WIDTH;

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_ACT   = 2'd2,
        PH_FRONT = 2'd3
    } phase_t;

    // A zero length would make the "last count" compare wrap to all-ones; run it as 1 instead.
    function automatic logic [W-1:0] eff_len(input logic [W-1:0] len);
        return (len == '0) ? W'(1) : len;
    endfunction

    function automatic logic [W-1:0] len_of(input phase_t ph,
                                            input logic [W-1:0] l_sync,
                                            input logic [W-1:0] l_back,
                                            input logic [W-1:0] l_act,
                                            input logic [W-1:0] l_front);
        logic [W-1:0] l;
        case (ph)
            PH_SYNC:  l = l_sync;
            PH_BACK:  l = l_back;
            PH_ACT:   l = l_act;
            default:  l = l_front;
        endcase
        return eff_len(l);
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        phase_t n;
        case (ph)
            PH_SYNC:  n = PH_BACK;
            PH_BACK:  n = PH_ACT;
            PH_ACT:   n = PH_FRONT;
            default:  n = PH_SYNC;
        endcase
        return n;
    endfunction

    // Shadow configuration, only rewritten at the frame wrap.
    logic [W-1:0] h_sync_sh, h_back_sh, h_act_sh, h_front_sh;
    logic [W-1:0] v_sync_sh, v_back_sh, v_act_sh, v_front_sh;

    phase_t       h_ph, h_ph_nxt, v_ph, v_ph_nxt;
    logic [W-1:0] h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
    logic         h_last, v_last;
    logic         line_wrap, frame_wrap;

    // Next-state logic for both axes. The vertical axis steps only on the H FRONT->SYNC
    // wrap, so Vsync edges line up with the Hsync leading edge.
    always_comb begin
        h_ph_nxt   = h_ph;
        h_cnt_nxt  = h_cnt;
        v_ph_nxt   = v_ph;
        v_cnt_nxt  = v_cnt;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        h_last     = (h_cnt == len_of(h_ph, h_sync_sh, h_back_sh, h_act_sh, h_front_sh) - W'(1));
        v_last     = (v_cnt == len_of(v_ph, v_sync_sh, v_back_sh, v_act_sh, v_front_sh) - W'(1));
        if (Pix_en) begin
            if (h_last) begin
                h_cnt_nxt = '0;
                h_ph_nxt  = next_phase(h_ph);
                if (h_ph == PH_FRONT) begin
                    line_wrap = 1'b1;
                    if (v_last) begin
                        v_cnt_nxt  = '0;
                        v_ph_nxt   = next_phase(v_ph);
                        frame_wrap = (v_ph == PH_FRONT);
                    end else begin
                        v_cnt_nxt = v_cnt + W'(1);
                    end
                end
            end else begin
                h_cnt_nxt = h_cnt + W'(1);
            end
        end
    end

    // State register plus outputs registered from the next state, so every output
    // describes the phase/count the FSMs are sitting in.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            h_ph        <= PH_SYNC;
            v_ph        <= PH_SYNC;
            h_cnt       <= '0;
            v_cnt       <= '0;
            Hsync       <= H_POL;
            Vsync       <= V_POL;
            De          <= 1'b0;
            X           <= '0;
            Y           <= '0;
            Line_start  <= 1'b0;
            Frame_start <= 1'b0;
        end else begin
            h_ph        <= h_ph_nxt;
            v_ph        <= v_ph_nxt;
            h_cnt       <= h_cnt_nxt;
            v_cnt       <= v_cnt_nxt;
            Hsync       <= (h_ph_nxt == PH_SYNC) ? H_POL : ~H_POL;
            Vsync       <= (v_ph_nxt == PH_SYNC) ? V_POL : ~V_POL;
            De          <= (h_ph_nxt == PH_ACT) && (v_ph_nxt == PH_ACT);
            X           <= (h_ph_nxt == PH_ACT) ? h_cnt_nxt : '0;
            Y           <= (v_ph_nxt == PH_ACT) ? v_cnt_nxt : '0;
            Line_start  <= line_wrap;
            Frame_start <= frame_wrap;
        end
    end

`ifdef VGA_TIMING_CHECK_EN
    logic cfg_zero;
    logic cfg_err_q;

    assign cfg_zero = (H_sync_len == '0) || (H_back_len == '0) ||
                      (H_act_len  == '0) || (H_front_len == '0) ||
                      (V_sync_len == '0) || (V_back_len == '0) ||
                      (V_act_len  == '0) || (V_front_len == '0);
    assign Cfg_err  = cfg_err_q;
`else
    logic cfg_zero;

    assign cfg_zero = 1'b0;
    assign Cfg_err  = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            h_sync_sh  <= H_SYNC_DEF;
            h_back_sh  <= H_BACK_DEF;
            h_act_sh   <= H_ACT_DEF;
            h_front_sh <= H_FRONT_DEF;
            v_sync_sh  <= V_SYNC_DEF;
            v_back_sh  <= V_BACK_DEF;
            v_act_sh   <= V_ACT_DEF;
            v_front_sh <= V_FRONT_DEF;
        end else if (frame_wrap && !cfg_zero) begin
            h_sync_sh  <= H_sync_len;
            h_back_sh  <= H_back_len;
            h_act_sh   <= H_act_len;
            h_front_sh <= H_front_len;
            v_sync_sh  <= V_sync_len;
            v_back_sh  <= V_back_len;
            v_act_sh   <= V_act_len;
            v_front_sh <= V_front_len;
        end
    end

`ifdef VGA_TIMING_CHECK_EN
    // Sticky until reset: a rejected reload is flagged from the first pixel of the new frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cfg_err_q <= 1'b0;
        end else if (frame_wrap && cfg_zero) begin
            cfg_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with short timings (H 2/3/4/1, V 1/2/3/1).
// A second instance with inverted sync polarity shares all inputs.
// Expected values come from frame-position arithmetic on the programmed lengths.

module tb_vga_timing_gen;

    localparam int W = 11;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Pix_en;
    logic [W-1:0] H_sync_len, H_back_len, H_act_len, H_front_len;
    logic [W-1:0] V_sync_len, V_back_len, V_act_len, V_front_len;

    logic         Hsync, Vsync, De, Line_start, Frame_start, Cfg_err;
    logic [W-1:0] X, Y;
    logic         pol_hsync, pol_vsync, pol_de, pol_line_start, pol_frame_start, pol_cfg_err;
    logic [W-1:0] pol_x, pol_y;

    vga_timing_gen #(
        .REZ_MAX_WIDTH(W), .H_POL(1'b0), .V_POL(1'b0),
        .H_SYNC_DEF(11'd2), .H_BACK_DEF(11'd3), .H_ACT_DEF(11'd4), .H_FRONT_DEF(11'd1),
        .V_SYNC_DEF(11'd1), .V_BACK_DEF(11'd2), .V_ACT_DEF(11'd3), .V_FRONT_DEF(11'd1)
    ) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Pix_en(Pix_en),
        .H_sync_len(H_sync_len), .H_back_len(H_back_len),
        .H_act_len(H_act_len), .H_front_len(H_front_len),
        .V_sync_len(V_sync_len), .V_back_len(V_back_len),
        .V_act_len(V_act_len), .V_front_len(V_front_len),
        .Hsync(Hsync), .Vsync(Vsync), .De(De), .X(X), .Y(Y),
        .Line_start(Line_start), .Frame_start(Frame_start), .Cfg_err(Cfg_err)
    );

    vga_timing_gen #(
        .REZ_MAX_WIDTH(W), .H_POL(1'b1), .V_POL(1'b1),
        .H_SYNC_DEF(11'd2), .H_BACK_DEF(11'd3), .H_ACT_DEF(11'd4), .H_FRONT_DEF(11'd1),
        .V_SYNC_DEF(11'd1), .V_BACK_DEF(11'd2), .V_ACT_DEF(11'd3), .V_FRONT_DEF(11'd1)
    ) u_pol (
        .Clk(Clk), .Rst_n(Rst_n), .Pix_en(Pix_en),
        .H_sync_len(H_sync_len), .H_back_len(H_back_len),
        .H_act_len(H_act_len), .H_front_len(H_front_len),
        .V_sync_len(V_sync_len), .V_back_len(V_back_len),
        .V_act_len(V_act_len), .V_front_len(V_front_len),
        .Hsync(pol_hsync), .Vsync(pol_vsync), .De(pol_de), .X(pol_x), .Y(pol_y),
        .Line_start(pol_line_start), .Frame_start(pol_frame_start), .Cfg_err(pol_cfg_err)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Timing the bench currently expects the DUT to be running.
    int e_hs = 2, e_hb = 3, e_ha = 4, e_hf = 1;
    int e_vs = 1, e_vb = 2, e_va = 3, e_vf = 1;
    bit e_err = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk_eq({tag, " hsync"},  32'(Hsync),       32'd0);
        chk_eq({tag, " vsync"},  32'(Vsync),       32'd0);
        chk_eq({tag, " de"},     32'(De),          32'd0);
        chk_eq({tag, " x"},      32'(X),           32'd0);
        chk_eq({tag, " y"},      32'(Y),           32'd0);
        chk_eq({tag, " ls"},     32'(Line_start),  32'd0);
        chk_eq({tag, " fs"},     32'(Frame_start), 32'd0);
        chk_eq({tag, " err"},    32'(Cfg_err),     32'd0);
        chk_eq({tag, " phsync"}, 32'(pol_hsync),   32'd1);
        chk_eq({tag, " pvsync"}, 32'(pol_vsync),   32'd1);
    endtask

    // Expected outputs at position pos (pixels since the start of the frame).
    task automatic check_pos(input int pos, input bit strb, input string tag);
        int  ll, p, ln;
        bit  hs_a, vs_a, h_act, v_act;
        string t;
        ll    = e_hs + e_hb + e_ha + e_hf;
        p     = pos % ll;
        ln    = pos / ll;
        hs_a  = (p < e_hs);
        vs_a  = (ln < e_vs);
        h_act = (p >= e_hs + e_hb) && (p < e_hs + e_hb + e_ha);
        v_act = (ln >= e_vs + e_vb) && (ln < e_vs + e_vb + e_va);
        t = $sformatf("%s@%0d", tag, pos);
        chk_eq({t, " hsync"},  32'(Hsync),       hs_a ? 32'd0 : 32'd1);
        chk_eq({t, " vsync"},  32'(Vsync),       vs_a ? 32'd0 : 32'd1);
        chk_eq({t, " phsync"}, 32'(pol_hsync),   hs_a ? 32'd1 : 32'd0);
        chk_eq({t, " pvsync"}, 32'(pol_vsync),   vs_a ? 32'd1 : 32'd0);
        chk_eq({t, " de"},     32'(De),          32'(h_act && v_act));
        chk_eq({t, " x"},      32'(X),           h_act ? 32'(p - e_hs - e_hb) : 32'd0);
        chk_eq({t, " y"},      32'(Y),           v_act ? 32'(ln - e_vs - e_vb) : 32'd0);
        chk_eq({t, " ls"},     32'(Line_start),  32'(strb && (p == 0)));
        chk_eq({t, " fs"},     32'(Frame_start), 32'(strb && (pos == 0)));
        chk_eq({t, " err"},    32'(Cfg_err),     32'(e_err));
    endtask

    // Walks n positions of a frame starting at position 0 (already entered). With alt set,
    // every tick is followed by a Pix_en=0 Clk that must hold state and drop the strobes.
    // At position chg_at the H inputs are switched to 3/3/4/2.
    task automatic run_frame(input string tag, input bit first, input bit alt,
                             input int n, input int chg_at);
        for (int pos = 0; pos < n; pos++) begin
            if (pos == chg_at) begin
                H_sync_len  = 11'd3;
                H_back_len  = 11'd3;
                H_act_len   = 11'd4;
                H_front_len = 11'd2;
            end
            check_pos(pos, !(first && pos == 0), tag);
            if (alt) begin
                Pix_en = 1'b0;
                @(negedge Clk);
                check_pos(pos, 1'b0, {tag, " hold"});
                Pix_en = 1'b1;
            end
            @(negedge Clk);
        end
    endtask

    task automatic set_h_default();
        H_sync_len  = 11'd2;
        H_back_len  = 11'd3;
        H_act_len   = 11'd4;
        H_front_len = 11'd1;
    endtask

    initial begin
        Rst_n  = 1'b0;
        Pix_en = 1'b1;
        set_h_default();
        V_sync_len  = 11'd1;
        V_back_len  = 11'd2;
        V_act_len   = 11'd3;
        V_front_len = 11'd1;

        #12;
        check_reset("rst");

        // Free-running: first frame without a start strobe, then Frame_start at cycle 70.
        @(negedge Clk);
        Rst_n = 1'b1;
        run_frame("f1", 1'b1, 1'b0, 70, -1);
        run_frame("f2", 1'b0, 1'b0, 70, -1);

        // Pix_en alternating 1/0.
        run_frame("alt", 1'b0, 1'b1, 70, -1);

        // New H timing written mid-frame only takes effect from the next frame.
        run_frame("cfg_old", 1'b0, 1'b0, 70, 20);
        e_hs = 3; e_hb = 3; e_ha = 4; e_hf = 2;
        set_h_default();
        run_frame("cfg_new", 1'b0, 1'b0, 84, -1);
        e_hs = 2; e_hb = 3; e_ha = 4; e_hf = 1;

        // Asynchronous reset in the middle of the active area.
        run_frame("pre_rst", 1'b0, 1'b0, 36, -1);
        check_pos(36, 1'b1, "mid_de");
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge Clk);
        Rst_n = 1'b1;
        run_frame("post_rst", 1'b1, 1'b0, 70, -1);

        // Zero active-line length presented for the next reload.
        V_act_len = 11'd0;
        run_frame("zero_pre", 1'b0, 1'b0, 70, -1);
`ifdef VGA_TIMING_CHECK_EN
        e_err = 1'b1;
        run_frame("zero_rej", 1'b0, 1'b0, 70, -1);
`else
        e_va = 1;
        run_frame("zero_one", 1'b0, 1'b0, 50, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
